// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the RAM arbiter: controller state encoding and
// default geometry of the attached RAM.
package ram_ctrl_pkg;

  localparam logic STATE_INIT  = 1'b0;
  localparam logic STATE_SERVE = 1'b1;

  localparam int ADDR_SIZE_DEF   = 10;
  localparam int WORD_SIZE_DEF   = 8;
  localparam int MEMORY_SIZE_DEF = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the requests;
// the pointer remembers who won last and moves only when a grant is issued.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // r_last = 1 means requester 1 won most recently, so requester 0 wins a tie.
  logic r_last;

  always_comb begin
    gnt0 = req0 & (~req1 | r_last);
    gnt1 = req1 & (~req0 | ~r_last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (gnt0) begin
      r_last <= 1'b0;
    end else if (gnt1) begin
      r_last <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one combinational-read RAM between two requesters: clears the RAM
// after reset or on init_start, then serves one round-robin access per cycle.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int addr_size   = ADDR_SIZE_DEF,
  parameter int word_size   = WORD_SIZE_DEF,
  parameter int memory_size = MEMORY_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_start,
  output logic                 init_busy,
  input  logic                 req0,
  input  logic                 wr0,
  input  logic [addr_size-1:0] addr0,
  input  logic [word_size-1:0] din0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [word_size-1:0] dout0,
  input  logic                 req1,
  input  logic                 wr1,
  input  logic [addr_size-1:0] addr1,
  input  logic [word_size-1:0] din1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [word_size-1:0] dout1,
  output logic                 mem_cs,
  output logic                 mem_wr,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_din,
  input  logic [word_size-1:0] mem_dout
);

  localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(memory_size - 1);
  localparam logic [addr_size:0]   MEM_WORDS = (addr_size + 1)'(memory_size);

  logic                 r_state;
  logic [addr_size-1:0] r_cnt;
  logic                 r_rvalid0;
  logic                 r_rvalid1;
  logic [word_size-1:0] r_dout0;
  logic [word_size-1:0] r_dout1;

  logic w_serve;
  logic w_gnt0;
  logic w_gnt1;
  logic w_in_range0;
  logic w_in_range1;

  assign w_serve     = (r_state == STATE_SERVE);
  assign w_in_range0 = ({1'b0, addr0} < MEM_WORDS);
  assign w_in_range1 = ({1'b0, addr1} < MEM_WORDS);

  // Handshake: a requester holds req/wr/addr/din stable until gnt is seen high
  // in the same cycle; that cycle is the access. Read data follows one cycle
  // later with rvalid high for exactly one cycle. Dropping req before gnt
  // withdraws the request.
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (req0 & w_serve),
    .req1  (req1 & w_serve),
    .gnt0  (w_gnt0),
    .gnt1  (w_gnt1)
  );

  always_comb begin
    mem_cs   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (!w_serve) begin
      mem_cs   = 1'b1;
      mem_wr   = 1'b1;
      mem_addr = r_cnt;
    end else if (w_gnt0) begin
      mem_cs   = 1'b1;
      mem_wr   = wr0 & w_in_range0;
      mem_addr = addr0;
      mem_din  = din0;
    end else if (w_gnt1) begin
      mem_cs   = 1'b1;
      mem_wr   = wr1 & w_in_range1;
      mem_addr = addr1;
      mem_din  = din1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STATE_INIT;
      r_cnt   <= '0;
    end else if (!w_serve) begin
      r_cnt <= r_cnt + addr_size'(1);
      if (r_cnt == LAST_ADDR) begin
        r_state <= STATE_SERVE;
        r_cnt   <= '0;
      end
    end else if (init_start) begin
      r_state <= STATE_INIT;
      r_cnt   <= '0;
    end
  end

  // Out-of-range reads still complete, returning zero instead of RAM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_dout0   <= '0;
      r_dout1   <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~wr0;
      r_rvalid1 <= w_gnt1 & ~wr1;
      if (w_gnt0 && !wr0) r_dout0 <= w_in_range0 ? mem_dout : '0;
      if (w_gnt1 && !wr1) r_dout1 <= w_in_range1 ? mem_dout : '0;
    end
  end

  assign init_busy = (r_state == STATE_INIT);
  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign dout0     = r_dout0;
  assign dout1     = r_dout1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a 16-word memory: clear sweeps, round-robin
// grants, read returns, out-of-range handling and reset in mid-operation.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_start;
  logic          init_busy;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] dout0, dout1;
  logic          mem_cs, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  // clock / reset
  always #5 clk = ~clk;

  // RAM: combinational read, write on cs&wr
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign mem_dout = ram[mem_addr];
  always @(posedge clk) if (mem_cs && mem_wr) ram[mem_addr] <= mem_din;

  ram_arbiter #(.addr_size(AW), .word_size(DW), .memory_size(MS)) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_busy(init_busy),
    .req0(req0), .wr0(wr0), .addr0(addr0), .din0(din0),
    .gnt0(gnt0), .rvalid0(rvalid0), .dout0(dout0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .din1(din1),
    .gnt1(gnt1), .rvalid1(rvalid1), .dout1(dout1),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  typedef struct {
    logic          is;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          e0, e1;
  } vec_t;

  vec_t          tab[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] model [0:MS-1];
  logic          pend0, pend1;
  logic [DW-1:0] last0, last1;
  int            errors = 0;
  int            checks = 0;

  function automatic vec_t mk(input logic is, input logic r0, input logic w0,
                              input int a0, input int d0, input logic r1,
                              input logic w1, input int a1, input int d1,
                              input logic e0, input logic e1);
    vec_t v;
    v.is = is; v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // scoreboard: compare read returns that were scheduled in the previous cycle
  task automatic check_returns();
    logic [DW-1:0] e;
    chk("rvalid0", rvalid0, pend0);
    if (pend0) begin
      e = exp_q0.pop_front();
      chk("dout0", dout0, e);
      last0 = e;
    end else chk("dout0_hold", dout0, last0);
    chk("rvalid1", rvalid1, pend1);
    if (pend1) begin
      e = exp_q1.pop_front();
      chk("dout1", dout1, e);
      last1 = e;
    end else chk("dout1_hold", dout1, last1);
    pend0 = 1'b0;
    pend1 = 1'b0;
  endtask

  // driver: one cycle, entered and left at a falling edge
  task automatic run_vec(input vec_t v);
    logic          w, inr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    init_start = v.is;
    req0 = v.r0; wr0 = v.w0; addr0 = v.a0; din0 = v.d0;
    req1 = v.r1; wr1 = v.w1; addr1 = v.a1; din1 = v.d1;
    #1;
    check_returns();
    chk("gnt0", gnt0, v.e0);
    chk("gnt1", gnt1, v.e1);
    if (v.e0 || v.e1) begin
      w = v.e0 ? v.w0 : v.w1;
      a = v.e0 ? v.a0 : v.a1;
      d = v.e0 ? v.d0 : v.d1;
      inr = (a < AW'(MS));
      chk("mem_cs", mem_cs, 1'b1);
      chk("mem_addr", mem_addr, a);
      chk("mem_wr", mem_wr, w & inr);
      if (w) begin
        chk("mem_din", mem_din, d);
        if (inr) model[a[3:0]] = d;
      end else begin
        if (v.e0) begin exp_q0.push_back(inr ? model[a[3:0]] : '0); pend0 = 1'b1; end
        else      begin exp_q1.push_back(inr ? model[a[3:0]] : '0); pend1 = 1'b1; end
      end
    end else begin
      chk("mem_cs_idle", mem_cs, 1'b0);
      chk("mem_wr_idle", mem_wr, 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic run_table();
    foreach (tab[i]) run_vec(tab[i]);
    tab.delete();
  endtask

  // clear sweep checker; requests and init_start are held high and must be ignored
  task automatic sweep(input int n, input logic full);
    for (int i = 0; i < n; i++) begin
      init_start = 1'b1;
      req0 = 1'b1; wr0 = 1'b1; addr0 = AW'(9); din0 = 8'h5A;
      req1 = 1'b1; wr1 = 1'b0; addr1 = AW'(2); din1 = 8'h00;
      #1;
      check_returns();
      chk("sweep_busy", init_busy, 1'b1);
      chk("sweep_cs", mem_cs, 1'b1);
      chk("sweep_wr", mem_wr, 1'b1);
      chk("sweep_addr", mem_addr, AW'(i));
      chk("sweep_din", mem_din, 8'h00);
      chk("sweep_gnt0", gnt0, 1'b0);
      chk("sweep_gnt1", gnt1, 1'b0);
      @(negedge clk);
    end
    if (full) begin
      for (int i = 0; i < MS; i++) model[i] = '0;
      init_start = 1'b0; req0 = 1'b0; req1 = 1'b0;
      #1;
      check_returns();
      chk("sweep_done_busy", init_busy, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    pend0 = 1'b0; pend1 = 1'b0; last0 = '0; last1 = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'($urandom_range(1, 255));
    for (int i = 0; i < MS; i++) model[i] = DW'($urandom_range(0, 255));
    reset = 1'b1; init_start = 1'b0;
    req0 = 1'b1; wr0 = 1'b0; addr0 = '0; din0 = '0;
    req1 = 1'b1; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", init_busy, 1'b1);
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_rvalid1", rvalid1, 1'b0);
    chk("rst_dout0", dout0, 8'h00);
    chk("rst_dout1", dout1, 8'h00);
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_addr", mem_addr, AW'(0));
    @(negedge clk);
    reset = 1'b0;
    sweep(MS, 1'b1);

    // writes, reads, round-robin, out-of-range, withdrawn request
    tab.push_back(mk(0, 1,1,3,8'hA5, 0,0,0,0,    1,0));
    tab.push_back(mk(0, 1,0,3,0,     0,0,0,0,    1,0));
    tab.push_back(mk(0, 0,0,0,0,     0,0,0,0,    0,0));
    tab.push_back(mk(0, 1,0,5,0,     1,1,5,8'h3C,0,1));
    tab.push_back(mk(0, 1,0,5,0,     0,0,0,0,    1,0));
    tab.push_back(mk(0, 1,0,3,0,     1,0,5,0,    0,1));
    tab.push_back(mk(0, 1,0,3,0,     1,0,5,0,    1,0));
    tab.push_back(mk(0, 1,0,3,0,     1,0,5,0,    0,1));
    tab.push_back(mk(0, 1,0,3,0,     1,0,5,0,    1,0));
    tab.push_back(mk(0, 1,0,20,0,    0,0,0,0,    1,0));
    tab.push_back(mk(0, 1,1,20,8'hFF,0,0,0,0,    1,0));
    tab.push_back(mk(0, 0,1,6,8'h77, 0,0,0,0,    0,0));
    tab.push_back(mk(0, 1,0,6,0,     0,0,0,0,    1,0));
    tab.push_back(mk(0, 0,0,0,0,     1,0,6,0,    0,1));
    tab.push_back(mk(0, 0,0,0,0,     1,0,20,0,   0,1));
    tab.push_back(mk(0, 0,0,0,0,     0,0,0,0,    0,0));
    run_table();

    // fill 0..3, then a new sweep requested alongside a granted read
    tab.push_back(mk(0, 0,0,0,0,     1,1,0,8'h11,0,1));
    tab.push_back(mk(0, 0,0,0,0,     1,1,1,8'h22,0,1));
    tab.push_back(mk(0, 0,0,0,0,     1,1,2,8'h33,0,1));
    tab.push_back(mk(0, 0,0,0,0,     1,1,3,8'h44,0,1));
    tab.push_back(mk(0, 1,0,2,0,     0,0,0,0,    1,0));
    tab.push_back(mk(1, 1,0,1,0,     0,0,0,0,    1,0));
    run_table();
    sweep(MS, 1'b1);
    tab.push_back(mk(0, 1,0,0,0,     0,0,0,0,    1,0));
    tab.push_back(mk(0, 0,0,0,0,     1,0,1,0,    0,1));
    tab.push_back(mk(0, 1,0,2,0,     0,0,0,0,    1,0));
    tab.push_back(mk(0, 0,0,0,0,     1,0,3,0,    0,1));
    tab.push_back(mk(1, 0,0,0,0,     0,0,0,0,    0,0));
    run_table();

    // reset at sweep address 7
    sweep(7, 1'b0);
    #1;
    chk("pre_reset_addr", mem_addr, AW'(7));
    reset = 1'b1;
    #1;
    chk("mid_reset_busy", init_busy, 1'b1);
    chk("mid_reset_addr", mem_addr, AW'(0));
    @(negedge clk);
    reset = 1'b0;
    sweep(MS, 1'b1);

    // reset while a read return is pending
    tab.push_back(mk(0, 1,1,3,8'hAB, 0,0,0,0,    1,0));
    tab.push_back(mk(0, 1,0,3,0,     0,0,0,0,    1,0));
    run_table();
    #1;
    reset = 1'b1;
    #1;
    chk("lost_rvalid0", rvalid0, 1'b0);
    chk("lost_dout0", dout0, 8'h00);
    chk("lost_dout1", dout1, 8'h00);
    exp_q0.delete(); exp_q1.delete();
    pend0 = 1'b0; pend1 = 1'b0; last0 = '0; last1 = '0;
    @(negedge clk);
    reset = 1'b0;
    sweep(MS, 1'b1);
    tab.push_back(mk(0, 1,0,3,0,     1,0,4,0,    1,0));
    tab.push_back(mk(0, 0,0,0,0,     1,0,4,0,    0,1));
    tab.push_back(mk(0, 0,0,0,0,     0,0,0,0,    0,0));
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester controller that shares one separate-data-line RAM (ram_3-style: combinational read, write on cs&wr) between clients.
- Sequences a hardware clear sweep after reset or on command.
- Then serves one access per cycle using round-robin arbitration.
- Sits between the RAM instance and two datapath masters.

Parameters:
addr_size, 10, width of all address buses
word_size, 8, data word width
memory_size, 1024, number of implemented words; the clear sweep covers 0..memory_size-1

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
init_start  input  1  single-cycle pulse requesting a new clear sweep
init_busy  output  1  high while the clear sweep runs
req0  input  1  requester 0 access request; held until granted
wr0  input  1  requester 0: 1=write, 0=read; valid with req0
addr0  input  addr_size  requester 0 address
din0  input  word_size  requester 0 write data
gnt0  output  1  requester 0 granted this cycle (combinational)
rvalid0  output  1  requester 0 read data valid (registered)
dout0  output  word_size  requester 0 read data
req1, wr1, addr1, din1, gnt1, rvalid1, dout1  same as requester 0, for requester 1
mem_cs  output  1  RAM chip select
mem_wr  output  1  RAM write enable
mem_addr  output  addr_size  RAM address
mem_din  output  word_size  RAM write data
mem_dout  input  word_size  RAM read data (combinational from mem_addr)

Behaviour:
- Reset (async): state=INIT, sweep counter=0, last-grant pointer=1 (requester 0 wins first), rvalid0/1=0, dout0/1=0, init_busy=1.
- INIT state:
  - Each cycle drive mem_cs=1, mem_wr=1, mem_addr=counter, mem_din=0; counter increments.
  - After the write of memory_size-1, move to SERVE; init_busy drops the next cycle.
  - Sweep length is exactly memory_size cycles.
  - gnt0 and gnt1 stay 0; requests wait.
  - init_start is ignored during INIT.
- SERVE state:
  - init_start=1 → INIT with counter=0 next cycle. An access granted in the same cycle still completes.
  - Arbitration is combinational in the same cycle:
    - Only one requester active → it is granted.
    - Both active → the one not granted last is granted.
    - The pointer updates only on a grant.
  - Granted cycle: mem_cs=1, mem_addr/mem_din from the winner, mem_wr=winner's wr.
  - No grant: mem_cs=0, mem_wr=0.
- Read latency: mem_dout is sampled at the end of the grant cycle. rvalidN=1 and doutN=data on the following cycle, for one cycle only. doutN holds its value afterwards.
- Writes complete at the grant-cycle edge. A read of the same address in the next cycle returns the new data.
- Out-of-range address (addr >= memory_size):
  - Still granted.
  - mem_wr forced 0.
  - A read returns dout=0 with rvalid=1.
- Requester handshake: req, wr, addr and din stay stable until gnt. Dropping req before gnt withdraws the request with no side effects.
- Back-to-back: the same requester may be granted on consecutive cycles if the other is idle.
- Reset asserted mid-sweep or mid-access: everything returns to reset values immediately. The sweep restarts from address 0. A pending rvalid is lost.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - state encoding (INIT=1'b0, SERVE=1'b1)
  - default addr_size, word_size and memory_size constants
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter (req0, req1, clk, reset → gnt0, gnt1, with the pointer register inside).
- Sweep counter and read-return registers stay in the top level.

Test Plan:
- Reset release, memory_size=16 → init_busy high for exactly 16 cycles; mem_wr=1 with mem_din=0 at addresses 0..15; no gnt during that time.
- After init, req0 writes 8'hA5 to addr 3, then reads addr 3 → gnt0 in both request cycles; rvalid0=1, dout0=8'hA5 one cycle after the read grant.
- req0 and req1 held high continuously with reads → grants alternate 0,1,0,1; each rvalid follows its own grant by 1 cycle.
- Requester 1 writes 8'h3C to addr 5 while requester 0 reads addr 5 in the next grant slot → dout0=8'h3C.
- init_start during SERVE after filling addr 0..3 → new 16-cycle sweep; later reads of addr 0..3 return 0.
- Reset asserted at sweep address 7, released → sweep restarts at address 0 and takes a full 16 cycles. Also check a read of addr 20 (memory_size=16) → mem_wr=0, dout=0, rvalid=1.
